rd_channel_arbiter: RTL

RD_CHANNEL_ARBITER -- requirements
Module: rd_channel_arbiter

---
 rtl/rd_channel_arbiter_pkg.sv | 21 ++
 rtl/rd_channel_arbiter_if.sv | 43 ++++
 rtl/rd_channel_arbiter_rr_arbiter2.sv | 31 +++
 rtl/rd_channel_arbiter.sv | 94 +++++++++
 4 files changed

// File: rtl/rd_channel_arbiter_pkg.sv
// rtl/rd_channel_arbiter_pkg.sv - shared widths, lane ids and tag helper for the read channel arbiter
package kmeansTypes;

  localparam int MAX_INFLIGHT_DEFAULT = 32;
  localparam int ADDR_W     = 58;
  localparam int LANE_TAG_W = 7;
  localparam int TX_TAG_W   = LANE_TAG_W + 1;
  localparam int DATA_W     = 512;
  localparam int CNT_W      = 7;
  localparam int DBG_W      = 32;

  typedef enum logic {
    LANE_TUPLE    = 1'b0,
    LANE_CENTROID = 1'b1
  } lane_e;

  function automatic logic [TX_TAG_W-1:0] make_tx_tag(input lane_e lane, input logic [LANE_TAG_W-1:0] tag);
    return {lane, tag};
  endfunction

endpackage

// File: rtl/rd_channel_arbiter_if.sv
// rtl/rd_channel_arbiter_if.sv - lane request/response streams and shared memory read channel
interface rd_channel_arbiter_if;
  import kmeansTypes::*;

  logic [ADDR_W-1:0]     req0_addr, req1_addr;
  logic [LANE_TAG_W-1:0] req0_tag, req1_tag;
  logic                  req0_valid, req1_valid, req0_ready, req1_ready;

  logic [ADDR_W-1:0]     um_tx_rd_addr;
  logic [TX_TAG_W-1:0]   um_tx_rd_tag;
  logic                  um_tx_rd_valid, um_tx_rd_ready;

  logic [TX_TAG_W-1:0]   um_rx_rd_tag;
  logic [DATA_W-1:0]     um_rx_data;
  logic                  um_rx_rd_valid, um_rx_rd_ready;

  logic [LANE_TAG_W-1:0] rsp0_tag, rsp1_tag;
  logic [DATA_W-1:0]     rsp0_data, rsp1_data;
  logic                  rsp0_valid, rsp1_valid, rsp0_ready, rsp1_ready;

  modport master (
    input  req0_addr, req1_addr, req0_tag, req1_tag, req0_valid, req1_valid,
    output req0_ready, req1_ready,
    output um_tx_rd_addr, um_tx_rd_tag, um_tx_rd_valid,
    input  um_tx_rd_ready,
    input  um_rx_rd_tag, um_rx_data, um_rx_rd_valid,
    output um_rx_rd_ready,
    output rsp0_tag, rsp1_tag, rsp0_data, rsp1_data, rsp0_valid, rsp1_valid,
    input  rsp0_ready, rsp1_ready
  );

  modport slave (
    output req0_addr, req1_addr, req0_tag, req1_tag, req0_valid, req1_valid,
    input  req0_ready, req1_ready,
    input  um_tx_rd_addr, um_tx_rd_tag, um_tx_rd_valid,
    output um_tx_rd_ready,
    output um_rx_rd_tag, um_rx_data, um_rx_rd_valid,
    input  um_rx_rd_ready,
    input  rsp0_tag, rsp1_tag, rsp0_data, rsp1_data, rsp0_valid, rsp1_valid,
    output rsp0_ready, rsp1_ready
  );

endinterface

// File: rtl/rd_channel_arbiter_rr_arbiter2.sv
// rtl/rd_channel_arbiter_rr_arbiter2.sv - two-way round-robin grant with a last-grant pointer
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,
  input  logic [1:0] req,
  input  logic       enable,
  output logic [1:0] grant
);

  // last_grant=1 means lane 1 won most recently, so lane 0 wins the next tie
  logic last_grant;

  always_comb begin
    grant = req;
    if (req == 2'b11) begin
      grant = last_grant ? 2'b01 : 2'b10;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= 1'b1;
    end else if (clear) begin
      last_grant <= 1'b1;
    end else if (enable && (req != 2'b00)) begin
      last_grant <= grant[1];
    end
  end

endmodule

// File: rtl/rd_channel_arbiter.sv
// rtl/rd_channel_arbiter.sv - merges two read lanes onto one memory channel and routes responses back by tag
module rd_channel_arbiter
  import kmeansTypes::*;
#(
  parameter int MAX_INFLIGHT = MAX_INFLIGHT_DEFAULT
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start_operator,
  rd_channel_arbiter_if.master        bus,
  output logic                        arb_error,
  output logic [1:0][DBG_W-1:0]       arb_debug_cnt
);

  logic [1:0]       eligible, grant, fire, rsp_fire;
  logic             can_accept, rsp_lane;
  logic [CNT_W-1:0] inflight [2];
  logic [DBG_W-1:0] dbg_cnt  [2];

  assign can_accept = !bus.um_tx_rd_valid || bus.um_tx_rd_ready;
  assign eligible[0] = bus.req0_valid && (inflight[0] < CNT_W'(MAX_INFLIGHT));
  assign eligible[1] = bus.req1_valid && (inflight[1] < CNT_W'(MAX_INFLIGHT));

  rr_arbiter2 u_rr (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (start_operator),
    .req    (eligible),
    .enable (can_accept),
    .grant  (grant)
  );

  assign fire           = can_accept ? grant : 2'b00;
  assign bus.req0_ready = fire[0];
  assign bus.req1_ready = fire[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.um_tx_rd_valid <= 1'b0;
      bus.um_tx_rd_addr  <= '0;
      bus.um_tx_rd_tag   <= '0;
    end else if (can_accept) begin
      bus.um_tx_rd_valid <= |fire;
      if (fire[0]) begin
        bus.um_tx_rd_addr <= bus.req0_addr;
        bus.um_tx_rd_tag  <= make_tx_tag(LANE_TUPLE, bus.req0_tag);
      end else if (fire[1]) begin
        bus.um_tx_rd_addr <= bus.req1_addr;
        bus.um_tx_rd_tag  <= make_tx_tag(LANE_CENTROID, bus.req1_tag);
      end
    end
  end

  // Responses pass straight through; the tag MSB picks the lane
  assign rsp_lane           = bus.um_rx_rd_tag[TX_TAG_W-1];
  assign bus.rsp0_tag       = bus.um_rx_rd_tag[LANE_TAG_W-1:0];
  assign bus.rsp1_tag       = bus.um_rx_rd_tag[LANE_TAG_W-1:0];
  assign bus.rsp0_data      = bus.um_rx_data;
  assign bus.rsp1_data      = bus.um_rx_data;
  assign bus.rsp0_valid     = bus.um_rx_rd_valid && !rsp_lane;
  assign bus.rsp1_valid     = bus.um_rx_rd_valid && rsp_lane;
  assign bus.um_rx_rd_ready = rsp_lane ? bus.rsp1_ready : bus.rsp0_ready;
  assign rsp_fire[0]        = bus.rsp0_valid && bus.rsp0_ready;
  assign rsp_fire[1]        = bus.rsp1_valid && bus.rsp1_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      arb_error <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        inflight[i]      <= '0;
        dbg_cnt[i]       <= '0;
        arb_debug_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (fire[i] && !rsp_fire[i]) begin
          inflight[i] <= inflight[i] + 1'b1;
        end else if (!fire[i] && rsp_fire[i] && (inflight[i] != '0)) begin
          inflight[i] <= inflight[i] - 1'b1;
        end
        if (rsp_fire[i] && (inflight[i] == '0)) begin
          arb_error <= 1'b1;
        end
        if (start_operator) begin
          dbg_cnt[i] <= '0;
        end else if (fire[i]) begin
          dbg_cnt[i] <= dbg_cnt[i] + 1'b1;
        end
        arb_debug_cnt[i] <= dbg_cnt[i];
      end
    end
  end

endmodule
